mem_arbiter: RTL and testbench

Two-port arbiter sharing the single unified instruction/data memory of the multicycle MIPS between the CPU datapath and a debug/loader port. Each requester issues one read or write at a time over a req/ack handshake. The arbiter latches the winner's command, drives the memory port, waits out the configured read latency, and returns data with a one-cycle ack. The control unit holds its current state until `cpu_ack`, so memory stalls are transparent to the datapath.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory arbiter of the multicycle MIPS.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between the CPU and debug ports.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with the CPU first.
module arb_pick
  import mips_mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic grant_en,
  output logic winner
);

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // On contention the port that was not granted last wins.
  always_comb begin
    winner = PORT_CPU;
    if (cpu_req && dbg_req) winner = ~last_grant;
    else if (dbg_req)       winner = PORT_DBG;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last_grant <= PORT_DBG;
    else if (grant_en) last_grant <= winner;
  end
`else
  always_comb begin
    winner = PORT_CPU;
    if (grant_en && dbg_req && !cpu_req) winner = PORT_DBG;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified MIPS memory between the CPU datapath and a debug port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(LAT + 1);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_en;
  logic             winner;

  assign grant_en = (state == IDLE) && (cpu_req || dbg_req);

  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .grant_en (grant_en),
    .winner   (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    busy       = (state != IDLE);
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    case (state)
      IDLE:  if (grant_en) state_next = ISSUE;
      ISSUE: begin
        mem_en     = 1'b1;
        state_next = mem_we ? ACK : WAIT;
      end
      WAIT:  if (wait_cnt == '0) state_next = ACK;
      ACK: begin
        cpu_ack    = (owner == PORT_CPU);
        dbg_ack    = (owner == PORT_DBG);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command fields are captured only at grant, so later requester changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= PORT_CPU;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (grant_en) begin
        owner     <= winner;
        mem_we    <= (winner == PORT_DBG) ? dbg_we    : cpu_we;
        mem_addr  <= (winner == PORT_DBG) ? dbg_addr  : cpu_addr;
        mem_wdata <= (winner == PORT_DBG) ? dbg_wdata : cpu_wdata;
      end
      if (state == ISSUE)
        wait_cnt <= CNT_W'(LAT - 1);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - CNT_W'(1);
      if (state == WAIT && wait_cnt == '0) begin
        if (owner == PORT_DBG) dbg_rdata <= mem_rdata;
        else                   cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (LAT=2) with a synchronous memory model.
// Honours MEM_ARB_RR_EN to select the expected arbitration policy.
module tb_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, owner;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears LAT=2 cycles after the strobe cycle.
  logic [31:0] mem_model [256];
  logic [31:0] stage1, stage2;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
    stage1 <= mem_model[mem_addr];
    stage2 <= stage1;
  end
  assign mem_rdata = stage2;

  logic [31:0] ref_mem [256];
  logic        model_last;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_last = PORT_DBG;
  endtask

  int          en_cyc, ack_cyc;
  logic [7:0]  en_addr;
  logic        en_we;
  logic [31:0] rd;

  // One complete transaction on a port; called at a negedge while the arbiter is idle.
  task automatic do_txn(input logic port, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata);
    if (port == PORT_DBG) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    en_cyc = -1; ack_cyc = -1; en_addr = '0; en_we = 1'b0; rd = '0;
    for (int i = 1; i <= 20 && ack_cyc < 0; i++) begin
      @(negedge clk);
      if (mem_en && en_cyc < 0) begin
        en_cyc = i; en_addr = mem_addr; en_we = mem_we;
      end
      if ((port == PORT_DBG) ? dbg_ack : cpu_ack) begin
        ack_cyc = i;
        rd = (port == PORT_DBG) ? dbg_rdata : cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
    check_output("ack_one_cycle", {31'b0, cpu_ack | dbg_ack}, 32'd0);
  endtask

  logic        pend [2];
  logic        p_we [2];
  logic [7:0]  p_addr [2];
  logic [31:0] p_wdata [2];
  logic        ack_now [2];
  logic        expect_issue, exp_win;

  initial begin
    int acks, cpu_n, dbg_n, wait_n;
    logic addr_ok;
    logic [31:0] got;
    logic q [$];

    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    model_last = PORT_DBG;
    @(negedge clk);
    @(negedge clk);
    check_output("reset_ctrl", {26'b0, busy, owner, mem_en, mem_we, cpu_ack, dbg_ack}, 32'd0);
    check_output("reset_addr", {24'b0, mem_addr}, 32'd0);
    check_output("reset_wdata", mem_wdata, 32'd0);
    check_output("reset_cpu_rdata", cpu_rdata, 32'd0);
    check_output("reset_dbg_rdata", dbg_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_txn(PORT_DBG, 1'b1, 8'h10, 32'hDEADBEEF);
    check_output("dbgw_en_cycle", en_cyc, 32'd1);
    check_output("dbgw_en_we", {31'b0, en_we}, 32'd1);
    check_output("dbgw_ack_cycle", ack_cyc, 32'd2);
    do_txn(PORT_DBG, 1'b1, 8'h20, 32'h12345678);
    check_output("dbgw2_ack_cycle", ack_cyc, 32'd2);
    do_txn(PORT_DBG, 1'b1, 8'h30, 32'h0BADF00D);
    check_output("dbgw3_ack_cycle", ack_cyc, 32'd2);

    do_txn(PORT_CPU, 1'b0, 8'h10, 32'h0);
    check_output("cpur_en_cycle", en_cyc, 32'd1);
    check_output("cpur_en_addr", {24'b0, en_addr}, 32'h10);
    check_output("cpur_en_we", {31'b0, en_we}, 32'd0);
    check_output("cpur_ack_cycle", ack_cyc, LAT + 2);
    check_output("cpur_rdata", rd, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check_output("cpur_rdata_held", cpu_rdata, 32'hDEADBEEF);

    do_txn(PORT_CPU, 1'b0, 8'h20, 32'h0);
    check_output("cpur_after_dbgw", rd, 32'h12345678);
    do_txn(PORT_CPU, 1'b1, 8'h50, 32'hAAAA5555);
    check_output("cpuw_ack_cycle", ack_cyc, 32'd2);
    check_output("cpuw_rdata_kept", cpu_rdata, 32'h12345678);

    // Requester changes its address and drops req right after grant.
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    acks = 0; addr_ok = 1'b1; got = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check_output("chg_en", {31'b0, mem_en}, 32'd1);
        cpu_addr = 8'h30;
        cpu_req = 1'b0;
      end
      if (mem_addr !== 8'h10) addr_ok = 1'b0;
      if (cpu_ack) begin
        acks++;
        got = cpu_rdata;
      end
    end
    check_output("chg_ack_count", acks, 32'd1);
    check_output("chg_addr_held", {31'b0, addr_ok}, 32'd1);
    check_output("chg_rdata", got, 32'hDEADBEEF);

    // Reset pulsed during WAIT drops the read.
    cpu_we = 1'b0; cpu_addr = 8'h20; cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("rstwait_ctrl", {28'b0, busy, mem_en, cpu_ack, owner}, 32'd0);
    check_output("rstwait_addr", {24'b0, mem_addr}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_last = PORT_DBG;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    check_output("rstwait_no_ack", acks, 32'd0);
    check_output("rstwait_rdata_clr", cpu_rdata, 32'd0);
    do_txn(PORT_CPU, 1'b0, 8'h20, 32'h0);
    check_output("rstwait_reissue_ack", ack_cyc, LAT + 2);
    check_output("rstwait_reissue_data", rd, 32'h12345678);

    // Both ports request continuously for 20 cycles.
    apply_reset();
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 8'h20; dbg_req = 1'b1;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack) q.push_back(PORT_CPU);
      if (dbg_ack) q.push_back(PORT_DBG);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    wait_n = 0;
    while (busy && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_output("cont_drain", {31'b0, busy}, 32'd0);
    cpu_n = 0; dbg_n = 0;
    foreach (q[i]) if (q[i] == PORT_DBG) dbg_n++; else cpu_n++;
    check_output("cont_grants", q.size(), 20 / (LAT + 3));
`ifdef MEM_ARB_RR_EN
    foreach (q[i]) check_output("cont_rr_order", {31'b0, q[i]}, i % 2);
`else
    check_output("cont_fixed_dbg", dbg_n, 32'd0);
    check_output("cont_fixed_cpu", cpu_n, 20 / (LAT + 3));
`endif

    // Randomized traffic against the reference memory and arbitration model.
    for (int a = 8'h40; a < 8'h50; a++) begin
      got = $urandom;
      do_txn(PORT_DBG, 1'b1, 8'(a), got);
      ref_mem[a] = got;
    end
    apply_reset();
    pend[0] = 0; pend[1] = 0;
    expect_issue = 1'b0; exp_win = PORT_CPU;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clk);
      if (expect_issue) begin
        check_output("rnd_owner", {31'b0, owner}, {31'b0, exp_win});
        check_output("rnd_en", {31'b0, mem_en}, 32'd1);
        check_output("rnd_addr", {24'b0, mem_addr}, {24'b0, p_addr[exp_win]});
        check_output("rnd_we", {31'b0, mem_we}, {31'b0, p_we[exp_win]});
        if (p_we[exp_win]) check_output("rnd_wdata", mem_wdata, p_wdata[exp_win]);
        expect_issue = 1'b0;
      end
      ack_now[0] = cpu_ack;
      ack_now[1] = dbg_ack;
      for (int p = 0; p < 2; p++) begin
        if (ack_now[p]) begin
          check_output("rnd_ack_pending", {31'b0, pend[p]}, 32'd1);
          if (pend[p]) begin
            if (p_we[p]) ref_mem[p_addr[p]] = p_wdata[p];
            else check_output("rnd_rdata", (p == 1) ? dbg_rdata : cpu_rdata, ref_mem[p_addr[p]]);
          end
          pend[p] = 1'b0;
        end else if (!pend[p] && cyc < 1500 && $urandom_range(0, 3) == 0) begin
          pend[p]    = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = 8'(8'h40 + $urandom_range(0, 15));
          p_wdata[p] = $urandom;
        end
      end
      cpu_req = pend[0]; cpu_we = p_we[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wdata[0];
      dbg_req = pend[1]; dbg_we = p_we[1]; dbg_addr = p_addr[1]; dbg_wdata = p_wdata[1];
      if (!busy && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
          exp_win = ~model_last;
`else
          exp_win = PORT_CPU;
`endif
        end else begin
          exp_win = pend[1] ? PORT_DBG : PORT_CPU;
        end
        model_last = exp_win;
        expect_issue = 1'b1;
      end
    end
    check_output("rnd_drain", {30'b0, pend[0], pend[1]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
